axis_bram_adapter_v1_0_line_packer: RTL and testbench

Upstream write-side packer for the AXIS-to-BRAM adapter. It accepts WORD_WIDTH-bit AXI-Stream beats and assembles BRAM_WIDTH_IN_WORD beats into one wide line. Each completed line is written to BRAM in a single-cycle write at a self-incrementing index, bounded by a start/bound window. It feeds the wide BRAM write port that the adapter's read-side controller later drains.

---
 rtl/axis_bram_adapter_v1_0_line_packer.sv | 152 +++++++++++++++
 tb/tb_axis_bram_adapter_v1_0_line_packer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_adapter_v1_0_line_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axis_bram_adapter_v1_0_line_packer                            |
// | Purpose  : Packs WORD_WIDTH-bit AXI-Stream beats into BRAM_WIDTH_IN_WORD- |
// |            word lines and writes each line to BRAM at a self-incrementing |
// |            index inside a start/bound window.                            |
// | Options  : LINE_PACKER_TLAST_PAD_EN - a tlast beat closes the line early, |
// |            leaving the remaining slots zero.                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module axis_bram_adapter_v1_0_line_packer #(
  parameter int WORD_WIDTH         = 32,
  parameter int BRAM_WIDTH_IN_WORD = 36,
  parameter int BRAM_DEPTH         = 12
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 addr_reload,
  input  logic [BRAM_DEPTH-1:0]                bram_start_index,
  input  logic [BRAM_DEPTH-1:0]                bram_bound_index,
  input  logic [WORD_WIDTH-1:0]                s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  output logic                                 bram_en,
  output logic                                 bram_wen,
  output logic [BRAM_DEPTH-1:0]                bram_index,
  output logic [WORD_WIDTH*BRAM_WIDTH_IN_WORD-1:0] bram_din,
  output logic                                 bram_last,
  output logic                                 full
);

  localparam int c_line_w = WORD_WIDTH * BRAM_WIDTH_IN_WORD;
  // BRAM_WIDTH_IN_WORD is at most 63, so six bits always hold a slot number.
  localparam int c_cnt_w  = 6;
  localparam logic [c_cnt_w-1:0] c_last_slot = c_cnt_w'(BRAM_WIDTH_IN_WORD - 1);
`ifdef LINE_PACKER_TLAST_PAD_EN
  localparam bit c_pad_en = 1'b1;
`else
  localparam bit c_pad_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WRITE = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [c_cnt_w-1:0]      word_cnt_q, word_cnt_d;
  logic [c_line_w-1:0]     din_q, din_d;
  logic                    last_flag_q, last_flag_d;
  logic                    en_q, en_d;
  logic                    bram_last_q, bram_last_d;
  logic [BRAM_DEPTH-1:0]   index_q, index_d;
  logic                    full_q, full_d;
  logic                    w_hs;

  // Ready only while filling; reload blocks the stream so no beat is lost.
  assign s_axis_tready = rstn && (state_q == FILL) && !addr_reload;
  assign w_hs          = s_axis_tvalid && s_axis_tready;

  assign bram_en    = en_q;
  assign bram_wen   = en_q;
  assign bram_index = index_q;
  assign bram_din   = din_q;
  assign bram_last  = bram_last_q;
  assign full       = full_q;

  // Next-state logic: reload overrides everything; WRITE is a single cycle.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    din_d       = din_q;
    last_flag_d = last_flag_q;
    index_d     = index_q;
    full_d      = full_q;
    en_d        = 1'b0;
    bram_last_d = 1'b0;

    if (addr_reload) begin
      state_d     = FILL;
      index_d     = bram_start_index;
      word_cnt_d  = '0;
      din_d       = '0;
      last_flag_d = 1'b0;
      full_d      = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (w_hs) begin
            for (int k = 0; k < BRAM_WIDTH_IN_WORD; k++) begin
              if (word_cnt_q == c_cnt_w'(k)) begin
                din_d[k*WORD_WIDTH +: WORD_WIDTH] = s_axis_tdata;
              end
            end
            word_cnt_d  = word_cnt_q + 1'b1;
            last_flag_d = last_flag_q | s_axis_tlast;
            if ((word_cnt_q == c_last_slot) || (c_pad_en && s_axis_tlast)) begin
              state_d     = WRITE;
              en_d        = 1'b1;
              bram_last_d = last_flag_d;
            end
          end
        end
        WRITE: begin
          word_cnt_d  = '0;
          din_d       = '0;
          last_flag_d = 1'b0;
          if (index_q == bram_bound_index) begin
            state_d = HALT;
            full_d  = 1'b1;
          end else begin
            index_d = index_q + 1'b1;
            state_d = FILL;
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= FILL;
      word_cnt_q  <= '0;
      din_q       <= '0;
      last_flag_q <= 1'b0;
      en_q        <= 1'b0;
      bram_last_q <= 1'b0;
      index_q     <= '0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      din_q       <= din_d;
      last_flag_q <= last_flag_d;
      en_q        <= en_d;
      bram_last_q <= bram_last_d;
      index_q     <= index_d;
      full_q      <= full_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_bram_adapter_v1_0_line_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_axis_bram_adapter_v1_0_line_packer                         |
// | Purpose  : Self-checking bench for the line packer against a queue-based  |
// |            reference model of the line assembly and write window.        |
// | Options  : honours LINE_PACKER_TLAST_PAD_EN when compiled with it.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_axis_bram_adapter_v1_0_line_packer;

  localparam int W  = 32;
  localparam int N  = 36;
  localparam int D  = 12;
  localparam int LW = W * N;
`ifdef LINE_PACKER_TLAST_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          addr_reload = 1'b0;
  logic [D-1:0]  bram_start_index = '0;
  logic [D-1:0]  bram_bound_index = '0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          bram_en;
  logic          bram_wen;
  logic [D-1:0]  bram_index;
  logic [LW-1:0] bram_din;
  logic          bram_last;
  logic          full;

  axis_bram_adapter_v1_0_line_packer #(
    .WORD_WIDTH(W), .BRAM_WIDTH_IN_WORD(N), .BRAM_DEPTH(D)
  ) dut (
    .clk(clk), .rstn(rstn), .addr_reload(addr_reload),
    .bram_start_index(bram_start_index), .bram_bound_index(bram_bound_index),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .bram_en(bram_en), .bram_wen(bram_wen), .bram_index(bram_index),
    .bram_din(bram_din), .bram_last(bram_last), .full(full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: accepted words of the line being built, write window state.
  logic [W-1:0] m_line[$];
  logic         m_lastf  = 1'b0;
  logic         m_wr     = 1'b0;
  logic         m_wlast  = 1'b0;
  logic [D-1:0] m_idx    = '0;
  logic         m_full   = 1'b0;
  logic         prev_en  = 1'b0;
  logic         accepted = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] pack_line();
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < m_line.size(); i++) r[i*W +: W] = m_line[i];
    return r;
  endfunction

  task automatic chk_din();
    logic [LW-1:0] e;
    int slot;
    e = pack_line();
    slot = -1;
    for (int i = N - 1; i >= 0; i--) if (bram_din[i*W +: W] !== e[i*W +: W]) slot = i;
    if (slot < 0) slot = 0;
    total++;
    assert (bram_din === e) else begin
      bad++;
      $error("FAIL din slot=%0d observed=%h expected=%h", slot, bram_din[slot*W +: W], e[slot*W +: W]);
    end
  endtask

  function automatic void model_reset();
    m_line.delete();
    m_lastf = 1'b0; m_wr = 1'b0; m_wlast = 1'b0;
    m_idx = '0; m_full = 1'b0; prev_en = 1'b0;
  endfunction

  // One clock: drive inputs, check ready, advance the model, check outputs.
  task automatic tick(input logic v, input logic [W-1:0] d, input logic l, input logic rl);
    logic exp_rdy;
    s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l; addr_reload = rl;
    #1;
    exp_rdy = !rl && !m_full && !m_wr;
    chk("tready", s_axis_tready, exp_rdy);
    accepted = v && exp_rdy;
    @(posedge clk);
    if (rl) begin
      m_idx = bram_start_index; m_line.delete(); m_lastf = 1'b0;
      m_full = 1'b0; m_wr = 1'b0;
    end else if (m_wr) begin
      m_line.delete(); m_lastf = 1'b0; m_wr = 1'b0;
      if (m_idx == bram_bound_index) m_full = 1'b1;
      else m_idx = m_idx + 1'b1;
    end else if (accepted) begin
      m_line.push_back(d);
      m_lastf = m_lastf | l;
      if (m_line.size() == N || (PAD && l)) begin
        m_wr = 1'b1; m_wlast = m_lastf;
      end
    end
    #1;
    chk("en", bram_en, m_wr);
    chk("wen", bram_wen, m_wr);
    chk("index", bram_index, m_idx);
    chk("full", full, m_full);
    chk_din();
    if (m_wr) chk("last", bram_last, m_wlast);
    chk("en_gap", prev_en && bram_en, 1'b0);
    prev_en = bram_en;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; addr_reload = 1'b0;
  endtask

  // Send n beats (tlast on beat tlast_at, 0 = none); base 0 means random data.
  task automatic send(input int n, input int tlast_at, input int stall_pct, input logic [W-1:0] base);
    int sent, budget;
    logic v;
    logic [W-1:0] d;
    sent = 0; budget = 0;
    while (sent < n && budget <= 4 * n + 50) begin
      v = ($urandom_range(99) >= stall_pct);
      d = (base != 0) ? base + W'(sent) : W'($urandom);
      tick(v, d, (sent + 1 == tlast_at), 1'b0);
      if (accepted) sent++;
      budget++;
    end
    total++;
    assert (sent == n) else begin
      bad++;
      $error("FAIL send_budget observed=%0d expected=%0d", sent, n);
    end
  endtask

  task automatic reload(input logic [D-1:0] s, input logic [D-1:0] b);
    bram_start_index = s; bram_bound_index = b;
    tick(1'b1, W'($urandom), 1'b0, 1'b1);
  endtask

  initial begin
    rstn = 1'b0;
    #2;
    chk("rst_en", bram_en, 1'b0);
    chk("rst_wen", bram_wen, 1'b0);
    chk("rst_idx", bram_index, '0);
    chk("rst_din", bram_din[63:0], 64'd0);
    chk("rst_last", bram_last, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_rdy", s_axis_tready, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();

    // Full line 1..36 at index 5, then a stalled random line at index 6.
    reload(12'd5, 12'd10);
    send(N, 0, 0, 32'd1);
    chk("line_en", bram_en, 1'b1);
    chk("line_idx", bram_index, 12'd5);
    chk("line_w0", bram_din[31:0], 32'd1);
    chk("line_w35", bram_din[35*W +: W], 32'd36);
    chk("line_last", bram_last, 1'b0);
    send(N, 0, 30, '0);
    chk("line2_idx", bram_index, 12'd6);
    tick(1'b0, '0, 1'b0, 1'b0);

    // Early tlast on beat 10.
    reload(12'd5, 12'd10);
    send(10, 10, 20, 32'd1);
    if (!PAD) begin
      chk("notpad_en", bram_en, 1'b0);
      send(N - 10, 0, 20, '0);
    end
    chk("tlast_en", bram_en, 1'b1);
    chk("tlast_idx", bram_index, 12'd5);
    chk("tlast_last", bram_last, 1'b1);
    chk("tlast_w9", bram_din[9*W +: W], 32'd10);
    tick(1'b0, '0, 1'b0, 1'b0);

    // Bound halt: writes at 3 and 4, then stalled.
    reload(12'd3, 12'd4);
    for (int i = 0; i < 3 * (N + 1) + 5; i++) tick(1'b1, W'($urandom), 1'b0, 1'b0);
    chk("halt_full", full, 1'b1);
    chk("halt_idx", bram_index, 12'd4);
    reload(12'd3, 12'd4);
    chk("rel_full", full, 1'b0);
    send(N, 0, 10, '0);
    chk("rel_idx", bram_index, 12'd3);
    tick(1'b0, '0, 1'b0, 1'b0);

    // Wrap: 4095, 0, 1 then full.
    reload(12'd4095, 12'd1);
    for (int i = 0; i < 3 * (N + 1) + 5; i++) tick(1'b1, W'($urandom), 1'b0, 1'b0);
    chk("wrap_full", full, 1'b1);
    chk("wrap_idx", bram_index, 12'd1);

    // Reset mid-line after 20 beats.
    reload(12'd9, 12'd100);
    send(20, 0, 0, '0);
    rstn = 1'b0;
    #1;
    chk("mid_en", bram_en, 1'b0);
    chk("mid_idx", bram_index, '0);
    chk("mid_din", (bram_din == '0), 1'b1);
    chk("mid_full", full, 1'b0);
    chk("mid_rdy", s_axis_tready, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    reload(12'd0, 12'd100);
    send(N, 0, 0, 32'd100);
    chk("mid_line_idx", bram_index, 12'd0);
    chk("mid_line_w0", bram_din[31:0], 32'd100);

    // Reload colliding with a WRITE cycle.
    tick(1'b0, '0, 1'b0, 1'b0);
    reload(12'd20, 12'd30);
    send(N, 0, 0, '0);
    chk("coll_en", bram_en, 1'b1);
    chk("coll_idx", bram_index, 12'd20);
    reload(12'd7, 12'd30);
    chk("coll_new_idx", bram_index, 12'd7);
    send(N, 0, 25, '0);
    chk("coll_line_idx", bram_index, 12'd7);
    tick(1'b0, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
